score_engine: RTL

SCORE_ENGINE -- requirements
Module: score_engine

---
 rtl/score_pkg.sv | 34 +++
 rtl/score_edge_gate.sv | 42 ++++
 rtl/score_engine.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/score_pkg.sv
// Shared types and the BCD digit adder for the score engine.
package score_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    COMMIT
  } state_t;

  typedef logic [3:0] bcd_digit_t;

  typedef struct packed {
    logic       carry;
    bcd_digit_t digit;
  } bcd_add_t;

  // One decimal digit of addition: a + b + cin, wrapped at 10 with carry out.
  function automatic bcd_add_t bcd_digit_add(input bcd_digit_t a,
                                             input bcd_digit_t b,
                                             input logic       cin);
    bcd_add_t   r;
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    if (s > 5'd9) begin
      r.carry = 1'b1;
      r.digit = bcd_digit_t'(s - 5'd10);
    end else begin
      r.carry = 1'b0;
      r.digit = s[3:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/score_edge_gate.sv
// Per-channel event qualifier: rising-edge detect, optional once-per-gate-window
// lockout, and the single pending flag consumed by the arbiter.
module score_edge_gate #(
  parameter bit ONCE = 1'b0
) (
  input  logic clk,
  input  logic resetN,
  input  logic game_on,
  input  logic ev_in,
  input  logic ev_gate,
  input  logic grant,
  output logic pending
);

  logic prev;
  logic used;
  logic hit;

  assign hit = ev_in & ~prev & ev_gate & game_on & ~(ONCE & used);

  // Previous ev_in level for edge detection.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) prev <= 1'b0;
    else         prev <= ev_in;
  end

  // Once-per-window lockout; released when the gate drops or the game stops.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)                  used <= 1'b0;
    else if (!game_on || !ev_gate) used <= 1'b0;
    else if (ONCE && hit)         used <= 1'b1;
  end

  // Pending flag: set by an accepted edge, cleared by grant or game end.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)       pending <= 1'b0;
    else if (!game_on) pending <= 1'b0;
    else if (grant)    pending <= 1'b0;
    else if (hit)      pending <= 1'b1;
  end

endmodule

// File: rtl/score_engine.sv
// BCD score accumulator: per-channel event gates, lowest-index arbiter and a
// digit-serial BCD adder with saturation at all 9s.
// Optional feature macro: SCORE_HISCORE_EN (adds hiscore_bcd / new_hiscore).
module score_engine
  import score_pkg::*;
#(
  parameter int unsigned                    NUM_EV    = 4,
  parameter int unsigned                    DIGITS    = 4,
  parameter logic [NUM_EV*DIGITS*4-1:0]     POINTS    = {16'h0100, 16'h0005, 16'h0050, 16'h0020},
  parameter logic [NUM_EV-1:0]              ONCE_MASK = 4'b0100
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  game_on,
  input  logic                  score_reset,
  input  logic [NUM_EV-1:0]     ev_in,
  input  logic [NUM_EV-1:0]     ev_gate,
  output logic [DIGITS*4-1:0]   score_bcd,
  output logic                  busy,
  output logic                  overflow
`ifdef SCORE_HISCORE_EN
  ,
  output logic [DIGITS*4-1:0]   hiscore_bcd,
  output logic                  new_hiscore
`endif
);

  localparam int unsigned DW = DIGITS * 4;
  localparam int unsigned CW = $clog2(DIGITS);
  localparam logic [DW-1:0] NINES = {DIGITS{4'h9}};

  state_t            state;
  state_t            state_nx;
  logic [NUM_EV-1:0] pend;
  logic [NUM_EV-1:0] grant;
  logic [DW-1:0]     pick_pts;
  logic              any_pend;
  logic              start;
  logic [DW-1:0]     acc;
  logic [DW-1:0]     addend;
  logic              carry;
  logic [CW-1:0]     dig_cnt;
  logic              last_digit;
  bcd_add_t          dsum;

  for (genvar g = 0; g < NUM_EV; g++) begin : g_ch
    score_edge_gate #(.ONCE(ONCE_MASK[g])) u_gate (
      .clk     (clk),
      .resetN  (resetN),
      .game_on (game_on),
      .ev_in   (ev_in[g]),
      .ev_gate (ev_gate[g]),
      .grant   (grant[g]),
      .pending (pend[g])
    );
  end

  assign any_pend   = |pend;
  assign start      = (state == IDLE) && game_on && any_pend;
  assign last_digit = (dig_cnt == CW'(DIGITS - 1));
  assign busy       = (state != IDLE) || any_pend;
  assign dsum       = bcd_digit_add(acc[3:0], addend[3:0], carry);

  // Lowest-index pending channel wins; its point value is muxed out alongside.
  always_comb begin
    logic found;
    found    = 1'b0;
    grant    = '0;
    pick_pts = '0;
    for (int unsigned i = 0; i < NUM_EV; i++) begin
      if (pend[i] && !found) begin
        found    = 1'b1;
        grant[i] = start;
        pick_pts = POINTS[i*DW +: DW];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= state_nx;
  end

  // FSM next state: ADD runs exactly DIGITS cycles, then one COMMIT cycle.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = ADD;
      ADD:     if (last_digit) state_nx = COMMIT;
      COMMIT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Digit-serial adder: operands shift right, sum digits enter at the top, so
  // after DIGITS shifts acc holds the full sum in its original digit order.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      acc     <= '0;
      addend  <= '0;
      carry   <= 1'b0;
      dig_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          acc     <= score_bcd;
          addend  <= pick_pts;
          carry   <= 1'b0;
          dig_cnt <= '0;
        end
        ADD: begin
          acc     <= {dsum.digit, acc[DW-1:4]};
          addend  <= {4'h0, addend[DW-1:4]};
          carry   <= dsum.carry;
          dig_cnt <= dig_cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Score register: cleared by score_reset while stopped, else written on COMMIT
  // with saturation when the MSD carried out.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      score_bcd <= '0;
      overflow  <= 1'b0;
    end else if (!game_on && score_reset) begin
      score_bcd <= '0;
      overflow  <= 1'b0;
    end else if (state == COMMIT) begin
      if (carry) begin
        score_bcd <= NINES;
        overflow  <= 1'b1;
      end else begin
        score_bcd <= acc;
      end
    end
  end

`ifdef SCORE_HISCORE_EN
  logic game_on_q;

  // High score capture on the game_on falling edge; packed BCD compares as binary.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      game_on_q   <= 1'b0;
      hiscore_bcd <= '0;
      new_hiscore <= 1'b0;
    end else begin
      game_on_q <= game_on;
      if (game_on_q && !game_on && (score_bcd > hiscore_bcd)) begin
        hiscore_bcd <= score_bcd;
        new_hiscore <= 1'b1;
      end else begin
        new_hiscore <= 1'b0;
      end
    end
  end
`endif

endmodule
